// File: rtl/array_arb_pkg.sv
// rtl/array_arb_pkg.sv - shared types and encodings for the two-requester array arbiter
package array_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } arb_state_t;

  localparam int ARRAY_WORDS = 4;

  localparam logic SEL_REQ1 = 1'b0;
  localparam logic SEL_REQ2 = 1'b1;

endpackage

// File: rtl/ArrayMUX2.sv
// rtl/ArrayMUX2.sv - 4-lane 2:1 array mux, sel 0 picks a, sel 1 picks b
module ArrayMUX2
  import array_arb_pkg::*;
#(
  parameter int bits = 8
) (
  input  logic                               sel,
  input  logic [ARRAY_WORDS-1:0][bits-1:0]   a,
  input  logic [ARRAY_WORDS-1:0][bits-1:0]   b,
  output logic [ARRAY_WORDS-1:0][bits-1:0]   y
);

  always_comb begin
    for (int i = 0; i < ARRAY_WORDS; i++) begin
      y[i] = sel ? b[i] : a[i];
    end
  end

endmodule

// File: rtl/array_out_stage.sv
// rtl/array_out_stage.sv - single-entry valid/ready register holding one array
module array_out_stage
  import array_arb_pkg::*;
#(
  parameter int bits = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [ARRAY_WORDS-1:0][bits-1:0]   data,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [ARRAY_WORDS-1:0][bits-1:0]   out_data
);

  // A load in the same cycle as out_ready replaces the departing array.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/array_rr_arbiter.sv
// rtl/array_rr_arbiter.sv - round-robin burst arbiter steering two array producers into one output stage
module array_rr_arbiter
  import array_arb_pkg::*;
#(
  parameter int bits      = 8,
  parameter int burst_len = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req1_valid,
  input  logic [ARRAY_WORDS-1:0][bits-1:0]   req1_data,
  output logic                               req1_ready,
  input  logic                               req2_valid,
  input  logic [ARRAY_WORDS-1:0][bits-1:0]   req2_data,
  output logic                               req2_ready,
  output logic                               out_valid,
  output logic [ARRAY_WORDS-1:0][bits-1:0]   out_data,
  input  logic                               out_ready,
  output logic                               grant,
  output logic                               busy
);

  localparam int CNT_W = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(burst_len - 1);

  arb_state_t                        state_q, state_d;
  logic                              last_q, last_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              grant_q, grant_d;
  logic                              load;
  logic                              stage_free;
  logic [ARRAY_WORDS-1:0][bits-1:0]  mux_data;

  assign stage_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SEL_REQ2;
      cnt_q   <= '0;
      grant_q <= SEL_REQ1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  // Ready depends only on state and the output stage, never on a valid input.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    req1_ready = 1'b0;
    req2_ready = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req1_valid && (!req2_valid || last_q == SEL_REQ2)) begin
          state_d = GRANT1;
          grant_d = SEL_REQ1;
        end else if (req2_valid) begin
          state_d = GRANT2;
          grant_d = SEL_REQ2;
        end
      end
      GRANT1: begin
        req1_ready = stage_free;
        if (!req1_valid) begin
          state_d = IDLE;
          last_d  = SEL_REQ1;
          cnt_d   = '0;
        end else if (stage_free) begin
          load = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            last_d  = SEL_REQ1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GRANT2: begin
        req2_ready = stage_free;
        if (!req2_valid) begin
          state_d = IDLE;
          last_d  = SEL_REQ2;
          cnt_d   = '0;
        end else if (stage_free) begin
          load = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            last_d  = SEL_REQ2;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  ArrayMUX2 #(.bits(bits)) u_mux (
    .sel (grant_q),
    .a   (req1_data),
    .b   (req2_data),
    .y   (mux_data)
  );

  array_out_stage #(.bits(bits)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (mux_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_array_rr_arbiter.sv
// tb/tb_array_rr_arbiter.sv - directed bench for array_rr_arbiter at burst_len 4 (u4) and 2 (u2)
module tb_array_rr_arbiter;

  typedef logic [3:0][7:0] arr_t;

  logic clk = 1'b0;
  logic rst;
  logic req1_valid, req2_valid, out_ready;
  arr_t req1_data, req2_data;

  logic r1_4, r2_4, ov_4, g_4, b_4;
  arr_t od_4;
  logic r1_2, r2_2, ov_2, g_2, b_2;
  arr_t od_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  array_rr_arbiter #(.bits(8), .burst_len(4)) u4 (
    .clk(clk), .rst(rst),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_4),
    .req2_valid(req2_valid), .req2_data(req2_data), .req2_ready(r2_4),
    .out_valid(ov_4), .out_data(od_4), .out_ready(out_ready),
    .grant(g_4), .busy(b_4)
  );

  array_rr_arbiter #(.bits(8), .burst_len(2)) u2 (
    .clk(clk), .rst(rst),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_2),
    .req2_valid(req2_valid), .req2_data(req2_data), .req2_ready(r2_2),
    .out_valid(ov_2), .out_data(od_2), .out_ready(out_ready),
    .grant(g_2), .busy(b_2)
  );

  function automatic arr_t mk(input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3);
    arr_t a;
    a[0] = w0; a[1] = w1; a[2] = w2; a[3] = w3;
    return a;
  endfunction

  function automatic arr_t seq_arr(input int i);
    return mk(8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req1_valid = 1'b0; req2_valid = 1'b0; out_ready = 1'b1;
    req1_data = '0; req2_data = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (ov_4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc %0d got %b exp 0", c, ov_4); end
      checks++; if (od_4 !== '0) begin errors++; $display("FAIL reset_out_data cyc %0d got %h exp 0", c, od_4); end
      checks++; if ({r1_4, r2_4} !== 2'b00) begin errors++; $display("FAIL reset_ready cyc %0d got %b exp 00", c, {r1_4, r2_4}); end
      checks++; if (g_4 !== 1'b0 || b_4 !== 1'b0) begin errors++; $display("FAIL reset_grant_busy cyc %0d got %b%b exp 00", c, g_4, b_4); end
    end
  endtask

  task automatic test_req1_alone;
    do_reset();
    req1_valid = 1'b1; req1_data = seq_arr(0);
    #1;
    checks++; if (r1_4 !== 1'b0) begin errors++; $display("FAIL alone_idle_ready got %b exp 0", r1_4); end
    tick();
    checks++; if (b_4 !== 1'b1 || g_4 !== 1'b0) begin errors++; $display("FAIL alone_grant1 busy/grant got %b%b exp 10", b_4, g_4); end
    for (int i = 0; i < 4; i++) begin
      req1_data = seq_arr(i);
      #1;
      checks++; if (r1_4 !== 1'b1) begin errors++; $display("FAIL alone_ready beat %0d got %b exp 1", i, r1_4); end
      tick();
      checks++; if (ov_4 !== 1'b1 || od_4 !== seq_arr(i)) begin errors++; $display("FAIL alone_beat %0d got v=%b d=%h exp v=1 d=%h", i, ov_4, od_4, seq_arr(i)); end
    end
    req1_data = seq_arr(0);
    checks++; if (b_4 !== 1'b0 || r1_4 !== 1'b0) begin errors++; $display("FAIL alone_burst_end busy/ready got %b%b exp 00", b_4, r1_4); end
    tick();
    checks++; if (b_4 !== 1'b1 || g_4 !== 1'b0 || ov_4 !== 1'b0) begin errors++; $display("FAIL alone_regrant busy/grant/ov got %b%b%b exp 100", b_4, g_4, ov_4); end
    req1_valid = 1'b0;
    tick();
    checks++; if (b_4 !== 1'b0) begin errors++; $display("FAIL alone_release busy got %b exp 0", b_4); end
  endtask

  task automatic test_contention;
    arr_t x1, x2, exp_d;
    logic [5:0] tbl [7];
    x1 = mk(8'h11, 8'h12, 8'h13, 8'h14);
    x2 = mk(8'h21, 8'h22, 8'h23, 8'h24);
    // busy, grant, out_valid, data_sel(2b: 0 none, 1 x1, 2 x2), then {r1,r2} derived
    tbl[0] = 6'b1_0_0_00_0; tbl[1] = 6'b1_0_1_01_0; tbl[2] = 6'b0_0_1_01_0;
    tbl[3] = 6'b1_1_0_00_0; tbl[4] = 6'b1_1_1_10_0; tbl[5] = 6'b0_1_1_10_0;
    tbl[6] = 6'b1_0_0_00_0;
    do_reset();
    req1_valid = 1'b1; req1_data = x1;
    req2_valid = 1'b1; req2_data = x2;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++; if (b_2 !== tbl[c][5] || g_2 !== tbl[c][4]) begin errors++; $display("FAIL contend_busy_grant cyc %0d got %b%b exp %b%b", c, b_2, g_2, tbl[c][5], tbl[c][4]); end
      checks++; if (ov_2 !== tbl[c][3]) begin errors++; $display("FAIL contend_out_valid cyc %0d got %b exp %b", c, ov_2, tbl[c][3]); end
      if (tbl[c][3]) begin
        exp_d = (tbl[c][2:1] == 2'b01) ? x1 : x2;
        checks++; if (od_2 !== exp_d) begin errors++; $display("FAIL contend_out_data cyc %0d got %h exp %h", c, od_2, exp_d); end
      end
      checks++; if (r1_2 !== (tbl[c][5] && !tbl[c][4]) || r2_2 !== (tbl[c][5] && tbl[c][4])) begin errors++; $display("FAIL contend_ready cyc %0d got %b%b", c, r1_2, r2_2); end
    end
    req1_valid = 1'b0; req2_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset();
    req1_valid = 1'b1; req1_data = seq_arr(0);
    tick();
    tick();
    req1_data = seq_arr(1);
    tick();
    checks++; if (od_4 !== seq_arr(1)) begin errors++; $display("FAIL bp_pre_stall data got %h exp %h", od_4, seq_arr(1)); end
    req1_data = seq_arr(2); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (r1_4 !== 1'b0) begin errors++; $display("FAIL bp_ready_drop cyc %0d got %b exp 0", c, r1_4); end
      tick();
      checks++; if (ov_4 !== 1'b1 || od_4 !== seq_arr(1) || b_4 !== 1'b1) begin errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%h busy=%b exp v=1 d=%h busy=1", c, ov_4, od_4, b_4, seq_arr(1)); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (r1_4 !== 1'b1) begin errors++; $display("FAIL bp_ready_return got %b exp 1", r1_4); end
    tick();
    checks++; if (od_4 !== seq_arr(2) || b_4 !== 1'b1) begin errors++; $display("FAIL bp_beat2 got d=%h busy=%b exp d=%h busy=1", od_4, b_4, seq_arr(2)); end
    req1_data = seq_arr(3);
    tick();
    checks++; if (od_4 !== seq_arr(3) || b_4 !== 1'b0) begin errors++; $display("FAIL bp_beat3_end got d=%h busy=%b exp d=%h busy=0", od_4, b_4, seq_arr(3)); end
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_early_release;
    arr_t bdat;
    bdat = mk(8'hb1, 8'hb2, 8'hb3, 8'hb4);
    do_reset();
    req2_valid = 1'b1; req2_data = bdat;
    req1_data = mk(8'ha1, 8'ha2, 8'ha3, 8'ha4);
    tick();
    checks++; if (b_4 !== 1'b1 || g_4 !== 1'b1) begin errors++; $display("FAIL early_grant2 got %b%b exp 11", b_4, g_4); end
    tick();
    checks++; if (ov_4 !== 1'b1 || od_4 !== bdat) begin errors++; $display("FAIL early_beat got v=%b d=%h exp v=1 d=%h", ov_4, od_4, bdat); end
    req2_valid = 1'b0; req1_valid = 1'b1;
    tick();
    checks++; if (b_4 !== 1'b0 || g_4 !== 1'b1) begin errors++; $display("FAIL early_idle got busy=%b grant=%b exp 0 1", b_4, g_4); end
    req2_valid = 1'b1;
    tick();
    checks++; if (b_4 !== 1'b1 || g_4 !== 1'b0) begin errors++; $display("FAIL early_tie_req1 got busy=%b grant=%b exp 1 0", b_4, g_4); end
    req1_valid = 1'b0; req2_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    req2_valid = 1'b1; req2_data = seq_arr(5);
    tick();
    tick();
    tick();
    checks++; if (od_4 !== seq_arr(5) || g_4 !== 1'b1) begin errors++; $display("FAIL midrst_pre got d=%h g=%b exp d=%h g=1", od_4, g_4, seq_arr(5)); end
    rst = 1'b1;
    tick();
    checks++; if (ov_4 !== 1'b0 || od_4 !== '0) begin errors++; $display("FAIL midrst_out got v=%b d=%h exp 0 0", ov_4, od_4); end
    checks++; if ({r1_4, r2_4, g_4, b_4} !== 4'b0000) begin errors++; $display("FAIL midrst_ctrl got %b exp 0000", {r1_4, r2_4, g_4, b_4}); end
    rst = 1'b0; req1_valid = 1'b1;
    tick();
    checks++; if (b_4 !== 1'b1 || g_4 !== 1'b0 || r1_4 !== 1'b1 || r2_4 !== 1'b0) begin errors++; $display("FAIL midrst_tie got busy=%b g=%b r=%b%b exp 1 0 10", b_4, g_4, r1_4, r2_4); end
    req1_valid = 1'b0; req2_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_req1_alone();
    test_contention();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
